flex_down_timer: RTL

FLEX_DOWN_TIMER -- requirements
Module: flex_down_timer

---
 rtl/flex_down_timer_if.sv | 51 +++++
 rtl/flex_down_timer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/flex_down_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : flex_down_timer_if
//  Description : Control/status bundle for the flex_down_timer block.
//                master : drives start/abort/load_val/prescale_val,
//                         observes count_out/tick_out/busy/done.
//                slave  : the timer itself (mirror directions).
//  Ports       : start, abort          - synchronous requests
//                load_val              - initial count (NUM_CNT_BITS)
//                prescale_val          - divider (NUM_PRE_BITS)
//                count_out             - registered current count
//                tick_out              - one-cycle pulse after each decrement
//                busy, done            - state decodes
//  Revision    : 1.0 - initial release
// ============================================================================
interface flex_down_timer_if #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_PRE_BITS = 4
);
    logic                    start;
    logic                    abort;
    logic [NUM_CNT_BITS-1:0] load_val;
    logic [NUM_PRE_BITS-1:0] prescale_val;
    logic [NUM_CNT_BITS-1:0] count_out;
    logic                    tick_out;
    logic                    busy;
    logic                    done;

    modport master (
        output start,
        output abort,
        output load_val,
        output prescale_val,
        input  count_out,
        input  tick_out,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  abort,
        input  load_val,
        input  prescale_val,
        output count_out,
        output tick_out,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/flex_down_timer.sv
`default_nettype none
// ============================================================================
//  Module      : flex_down_timer
//  Description : Loadable down-counter with a programmable prescaler.
//                An accepted start loads load_val and latches prescale_val;
//                the count then drops by one every prescale_val+1 cycles
//                until it reaches zero, where a one-cycle DONE state is
//                entered. abort cancels an active countdown.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                tmr  - flex_down_timer_if.slave (start, abort, load_val,
//                       prescale_val, count_out, tick_out, busy, done)
//  Revision    : 1.0 - initial release
// ============================================================================
module flex_down_timer #(
    parameter int NUM_CNT_BITS = 4,
    parameter int NUM_PRE_BITS = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    flex_down_timer_if.slave   tmr
);

    localparam logic [NUM_CNT_BITS-1:0] c_cnt_one = NUM_CNT_BITS'(1);
    localparam logic [NUM_PRE_BITS-1:0] c_pre_one = NUM_PRE_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [NUM_CNT_BITS-1:0] r_count;
    logic [NUM_PRE_BITS-1:0] r_pre;
    logic [NUM_PRE_BITS-1:0] r_pre_lim;
    logic                    r_tick;

    state_t                  w_state_next;
    logic [NUM_CNT_BITS-1:0] w_count_next;
    logic [NUM_PRE_BITS-1:0] w_pre_next;
    logic [NUM_PRE_BITS-1:0] w_pre_lim_next;
    logic                    w_tick_next;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_pre     <= '0;
            r_pre_lim <= '0;
            r_tick    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_pre     <= w_pre_next;
            r_pre_lim <= w_pre_lim_next;
            r_tick    <= w_tick_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / next-datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_pre_next     = r_pre;
        w_pre_lim_next = r_pre_lim;
        w_tick_next    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_count_next = '0;
                w_pre_next   = '0;
                // abort wins over start when both arrive together
                if (tmr.start && !tmr.abort) begin
                    w_pre_lim_next = tmr.prescale_val;
                    if (tmr.load_val != '0) begin
                        w_count_next = tmr.load_val;
                        w_state_next = S_RUN;
                    end else begin
                        // zero-length countdown: finish immediately
                        w_state_next = S_DONE;
                    end
                end
            end

            S_RUN: begin
                if (tmr.abort) begin
                    w_state_next = S_IDLE;
                    w_count_next = '0;
                    w_pre_next   = '0;
                end else if (r_pre == r_pre_lim) begin
                    w_pre_next  = '0;
                    w_tick_next = 1'b1;
                    // count is never zero in RUN; the guard keeps it from
                    // wrapping should that ever be violated
                    if (r_count != '0) begin
                        w_count_next = r_count - c_cnt_one;
                    end
                    if (r_count <= c_cnt_one) begin
                        w_state_next = S_DONE;
                    end
                end else begin
                    w_pre_next = r_pre + c_pre_one;
                end
            end

            S_DONE: begin
                // single-cycle state; abort and start have no effect here
                w_state_next = S_IDLE;
                w_count_next = '0;
                w_pre_next   = '0;
            end

            default: begin
                w_state_next = S_IDLE;
                w_count_next = '0;
                w_pre_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: registers or pure state decodes
    // ------------------------------------------------------------------
    assign tmr.count_out = r_count;
    assign tmr.tick_out  = r_tick;
    assign tmr.busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign tmr.done      = (r_state == S_DONE);

endmodule
`default_nettype wire
